// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq
// -----------------------------------------------------------------------------
// Multi-phase sequencer for the P-extension multiplier. Accepts one decoded
// multiply op per handshake, steps the shared multiplier datapath through
// 1..MaxMulPhases multiply phases plus an optional accumulate phase, then holds
// a result-valid handshake toward ID/EX until it is consumed.
//
// Build option: define IBEX_MULT_PEXT_SEQ_BYPASS_EN to let single-phase,
// non-accumulating ops complete in their accept cycle from IDLE.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   op_valid_i/op_ready_o  op handshake from decode
//   mode_i, mul_phases_i, accum_i, accum_sub_i, crossed_i  decoded op fields
//   kill_i                 flush the current op (wins over everything)
//   mul_en_o, phase_o      multiplier active / current 0-based phase
//   imd_we_o               write intermediate register (non-final phase)
//   acc_en_o               accumulate phase active
//   res_we_o               capture result this cycle
//   mode_o, accum_sub_o, crossed_o  latched op fields (0 while idle)
//   result_valid_o/result_ready_i   result handshake toward ID/EX
//   busy_o                 sequencer not idle
//   state_o                debug view of the FSM state
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising clock edge; valid never depends on ready, and once
// result_valid_o rises it stays high until result_ready_i (or kill_i / reset).
// -----------------------------------------------------------------------------
module ibex_mult_pext_seq #(
  parameter int MaxMulPhases = 2,
  parameter int PhW = (MaxMulPhases > 1) ? $clog2(MaxMulPhases) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           op_valid_i,
  output logic           op_ready_o,
  input  logic [1:0]     mode_i,
  input  logic [PhW:0]   mul_phases_i,
  input  logic           accum_i,
  input  logic [1:0]     accum_sub_i,
  input  logic           crossed_i,
  input  logic           kill_i,
  output logic           mul_en_o,
  output logic [PhW-1:0] phase_o,
  output logic           imd_we_o,
  output logic           acc_en_o,
  output logic           res_we_o,
  output logic [1:0]     mode_o,
  output logic [1:0]     accum_sub_o,
  output logic           crossed_o,
  output logic           result_valid_o,
  input  logic           result_ready_i,
  output logic           busy_o,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [PhW:0] MaxPh = (PhW+1)'(MaxMulPhases);

  state_e         state_q, state_d;
  logic [PhW-1:0] cnt_q, cnt_d;
  logic [PhW-1:0] last_q, last_d;
  logic           accum_q;
  logic [1:0]     mode_q, accum_sub_q;
  logic           crossed_q;
  logic           load;       // latch op fields this cycle
  logic           clear;      // wipe op fields (kill)
  logic           kill;
  logic [PhW:0]   eff, eff_m1;
  logic [PhW-1:0] eff_last;
  logic           bypass_ok;

  // Phase-count clamp: 0 means one phase, oversize saturates at the maximum.
  always_comb begin
    if (mul_phases_i == '0)        eff = (PhW+1)'(1);
    else if (mul_phases_i > MaxPh) eff = MaxPh;
    else                           eff = mul_phases_i;
    eff_m1   = eff - (PhW+1)'(1);
    eff_last = eff_m1[PhW-1:0];
  end

`ifdef IBEX_MULT_PEXT_SEQ_BYPASS_EN
  assign bypass_ok = (eff == (PhW+1)'(1)) && !accum_i;
`else
  assign bypass_ok = 1'b0;
`endif

  // While reset is held the outputs must show reset values, so neither an
  // offered op nor a kill may shape them.
  assign kill = kill_i & rst_ni;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    load           = 1'b0;
    clear          = 1'b0;
    op_ready_o     = 1'b0;
    mul_en_o       = 1'b0;
    phase_o        = '0;
    imd_we_o       = 1'b0;
    acc_en_o       = 1'b0;
    res_we_o       = 1'b0;
    result_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        op_ready_o = 1'b1;
        if (op_valid_i && !kill && rst_ni) begin
          load   = 1'b1;
          cnt_d  = '0;
          last_d = eff_last;
          if (bypass_ok) begin
            // Result produced in the accept cycle; park in DONE only if the
            // consumer cannot take it right away.
            mul_en_o       = 1'b1;
            res_we_o       = 1'b1;
            result_valid_o = 1'b1;
            state_d        = result_ready_i ? IDLE : DONE;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        mul_en_o = 1'b1;
        phase_o  = cnt_q;
        if (cnt_q != last_q) begin
          imd_we_o = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else if (accum_q) begin
          state_d = ACC;
        end else begin
          res_we_o = 1'b1;
          state_d  = DONE;
        end
      end
      ACC: begin
        acc_en_o = 1'b1;
        res_we_o = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          // Result consumed: ready for the next op in the same cycle.
          op_ready_o = 1'b1;
          state_d    = IDLE;
          if (op_valid_i) begin
            load    = 1'b1;
            cnt_d   = '0;
            last_d  = eff_last;
            state_d = MUL;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d        = IDLE;
      cnt_d          = '0;
      last_d         = '0;
      load           = 1'b0;
      clear          = 1'b1;
      op_ready_o     = 1'b0;
      result_valid_o = 1'b0;
      res_we_o       = 1'b0;
      imd_we_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      accum_q     <= 1'b0;
      mode_q      <= '0;
      accum_sub_q <= '0;
      crossed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (clear) begin
        accum_q     <= 1'b0;
        mode_q      <= '0;
        accum_sub_q <= '0;
        crossed_q   <= 1'b0;
      end else if (load) begin
        accum_q     <= accum_i;
        mode_q      <= mode_i;
        accum_sub_q <= accum_sub_i;
        crossed_q   <= crossed_i;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;
  // Latched fields are only meaningful while an op is in flight.
  assign mode_o      = busy_o ? mode_q      : 2'b00;
  assign accum_sub_o = busy_o ? accum_sub_q : 2'b00;
  assign crossed_o   = busy_o ? crossed_q   : 1'b0;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Testbench for ibex_mult_pext_seq (default parameters, MaxMulPhases=2).
// Inputs change 1 ns after the rising edge; outputs are checked 3 ns after
// the rising edge. obs packs the control outputs as
//   {op_ready, mul_en, imd_we, acc_en, res_we, result_valid, busy, phase}.
module tb_ibex_mult_pext_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       op_valid_i;
  logic       op_ready_o;
  logic [1:0] mode_i;
  logic [1:0] mul_phases_i;
  logic       accum_i;
  logic [1:0] accum_sub_i;
  logic       crossed_i;
  logic       kill_i;
  logic       mul_en_o;
  logic [0:0] phase_o;
  logic       imd_we_o;
  logic       acc_en_o;
  logic       res_we_o;
  logic [1:0] mode_o;
  logic [1:0] accum_sub_o;
  logic       crossed_o;
  logic       result_valid_o;
  logic       result_ready_i;
  logic       busy_o;
  logic [1:0] state_o;

  logic [7:0] obs;
  logic [4:0] fld;
  int n_pass = 0;
  int n_total = 0;

  assign obs = {op_ready_o, mul_en_o, imd_we_o, acc_en_o, res_we_o,
                result_valid_o, busy_o, phase_o};
  assign fld = {mode_o, accum_sub_o, crossed_o};

  always #5 clk_i = ~clk_i;

  ibex_mult_pext_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .mode_i(mode_i), .mul_phases_i(mul_phases_i), .accum_i(accum_i),
    .accum_sub_i(accum_sub_i), .crossed_i(crossed_i), .kill_i(kill_i),
    .mul_en_o(mul_en_o), .phase_o(phase_o), .imd_we_o(imd_we_o),
    .acc_en_o(acc_en_o), .res_we_o(res_we_o), .mode_o(mode_o),
    .accum_sub_o(accum_sub_o), .crossed_o(crossed_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid_i = 0; mode_i = 0; mul_phases_i = 0; accum_i = 0;
    accum_sub_i = 0; crossed_i = 0; kill_i = 0; result_ready_i = 1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [1:0] ph, input logic acc,
                       input logic [1:0] sub, input logic cr);
    op_valid_i = 1; mode_i = m; mul_phases_i = ph; accum_i = acc;
    accum_sub_i = sub; crossed_i = cr;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      op_valid_i = 1'($urandom_range(0, 1)); mode_i = 2'($urandom_range(0, 3));
      mul_phases_i = 2'($urandom_range(0, 3)); accum_i = 1'($urandom_range(0, 1));
      accum_sub_i = 2'($urandom_range(0, 3)); crossed_i = 1'($urandom_range(0, 1));
      result_ready_i = 1'($urandom_range(0, 1)); kill_i = 0;
      #1;
      n_total++;
      if (obs !== 8'b1000_0000 || fld !== 5'b0 || state_o !== 2'd0)
        $display("FAIL reset_outputs[%0d]: obs=%b fld=%b state=%0d, required obs=10000000 fld=00000 state=0",
                 i, obs, fld, state_o);
      else n_pass++;
    end
    step();
    idle_inputs();
    rst_ni = 1;
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL after_reset_idle: obs=%b required 10000000", obs);
    else n_pass++;
  endtask

  task automatic test_accum_two_phase();
    logic [7:0] exp_obs [5];
    exp_obs = '{8'b1000_0000, 8'b0110_0010, 8'b0100_0011, 8'b0001_1010, 8'b1000_0110};
    step();
    offer(2'd3, 2'd2, 1'b1, 2'b10, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) op_valid_i = 0;
      #2;
      n_total++;
      if (obs !== exp_obs[c])
        $display("FAIL accum2_cycle%0d: obs=%b required %b", c, obs, exp_obs[c]);
      else n_pass++;
      if (c >= 1) begin
        n_total++;
        if (fld !== 5'b11_10_1) $display("FAIL accum2_fields%0d: fld=%b required 11101", c, fld);
        else n_pass++;
      end
      step();
    end
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL accum2_back_idle: obs=%b required 10000000", obs);
    else n_pass++;
  endtask

  task automatic test_phase_clamp();
    // 0 requested phases runs one MUL cycle.
    step();
    offer(2'd0, 2'd0, 1'b0, 2'b00, 1'b0);
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b0100_1010) $display("FAIL clamp0_mul: obs=%b required 01001010", obs);
    else n_pass++;
    step();
    #2;
    n_total++;
    if (obs !== 8'b1000_0110) $display("FAIL clamp0_done: obs=%b required 10000110", obs);
    else n_pass++;
    // 3 (largest encodable, stands in for an oversize request) clamps to 2.
    step();
    offer(2'd2, 2'd3, 1'b0, 2'b00, 1'b0);
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b0110_0010) $display("FAIL clamp3_mul0: obs=%b required 01100010", obs);
    else n_pass++;
    step();
    #2;
    n_total++;
    if (obs !== 8'b0100_1011) $display("FAIL clamp3_mul1: obs=%b required 01001011", obs);
    else n_pass++;
    step();
    #2;
    n_total++;
    if (obs !== 8'b1000_0110) $display("FAIL clamp3_done: obs=%b required 10000110", obs);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    step();
    offer(2'd1, 2'd1, 1'b0, 2'b01, 1'b0);
    result_ready_i = 0;
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b0100_1010) $display("FAIL bp_mul: obs=%b required 01001010", obs);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step();
      #2;
      n_total++;
      if (obs !== 8'b0000_0110 || fld !== 5'b01_01_0)
        $display("FAIL bp_hold%0d: obs=%b fld=%b required 00000110 01010", c, obs, fld);
      else n_pass++;
    end
    // Release cycle with a new op offered back-to-back.
    step();
    result_ready_i = 1;
    offer(2'd2, 2'd1, 1'b0, 2'b00, 1'b0);
    #2;
    n_total++;
    if (obs !== 8'b1000_0110 || fld !== 5'b01_01_0)
      $display("FAIL bp_release: obs=%b fld=%b required 10000110 01010", obs, fld);
    else n_pass++;
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b0100_1010 || fld !== 5'b10_00_0)
      $display("FAIL back_to_back_mul: obs=%b fld=%b required 01001010 10000", obs, fld);
    else n_pass++;
    step();
    #2;
    n_total++;
    if (obs !== 8'b1000_0110) $display("FAIL back_to_back_done: obs=%b required 10000110", obs);
    else n_pass++;
  endtask

  task automatic test_kill();
    // Kill in MUL phase 0 of a 2-phase op.
    step();
    offer(2'd3, 2'd2, 1'b0, 2'b11, 1'b1);
    step();
    op_valid_i = 0;
    kill_i = 1;
    #2;
    n_total++;
    if (obs !== 8'b0100_0010) $display("FAIL kill_mul_cycle: obs=%b required 01000010", obs);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      step();
      kill_i = 0;
      #2;
      n_total++;
      if (obs !== 8'b1000_0000 || fld !== 5'b0)
        $display("FAIL kill_mul_after%0d: obs=%b fld=%b required 10000000 00000", c, obs, fld);
      else n_pass++;
    end
    // Kill in DONE with result_ready and a new op offered.
    step();
    offer(2'd1, 2'd1, 1'b0, 2'b00, 1'b0);
    result_ready_i = 0;
    step();
    op_valid_i = 0;
    step();
    #2;
    n_total++;
    if (obs !== 8'b0000_0110) $display("FAIL kill_done_pre: obs=%b required 00000110", obs);
    else n_pass++;
    step();
    kill_i = 1;
    result_ready_i = 1;
    offer(2'd2, 2'd2, 1'b1, 2'b01, 1'b1);
    #2;
    n_total++;
    if (obs !== 8'b0000_0010) $display("FAIL kill_done_cycle: obs=%b required 00000010", obs);
    else n_pass++;
    step();
    kill_i = 0;
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL kill_done_no_accept: obs=%b required 10000000", obs);
    else n_pass++;
    // Kill while idle blocks acceptance.
    step();
    kill_i = 1;
    offer(2'd1, 2'd1, 1'b0, 2'b00, 1'b0);
    #2;
    n_total++;
    if (obs !== 8'b0000_0000) $display("FAIL kill_idle_cycle: obs=%b required 00000000", obs);
    else n_pass++;
    step();
    kill_i = 0;
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL kill_idle_after: obs=%b required 10000000", obs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    step();
    offer(2'd3, 2'd2, 1'b1, 2'b10, 1'b0);
    step();
    op_valid_i = 0;
    #2;
    rst_ni = 0;
    #1;
    n_total++;
    if (obs !== 8'b1000_0000 || fld !== 5'b0)
      $display("FAIL reset_mid_op: obs=%b fld=%b required 10000000 00000", obs, fld);
    else n_pass++;
    step();
    rst_ni = 1;
    step();
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL reset_mid_op_after: obs=%b required 10000000", obs);
    else n_pass++;
  endtask

  task automatic test_bypass();
    step();
    offer(2'd1, 2'd1, 1'b0, 2'b00, 1'b0);
    result_ready_i = 1;
    #2;
`ifdef IBEX_MULT_PEXT_SEQ_BYPASS_EN
    n_total++;
    if (obs !== 8'b1100_1100) $display("FAIL bypass_accept: obs=%b required 11001100", obs);
    else n_pass++;
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL bypass_after: obs=%b required 10000000", obs);
    else n_pass++;
`else
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL nobypass_accept: obs=%b required 10000000", obs);
    else n_pass++;
    step();
    op_valid_i = 0;
    #2;
    n_total++;
    if (obs !== 8'b0100_1010) $display("FAIL nobypass_mul: obs=%b required 01001010", obs);
    else n_pass++;
    step();
    #2;
    n_total++;
    if (obs !== 8'b1000_0110) $display("FAIL nobypass_done: obs=%b required 10000110", obs);
    else n_pass++;
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_accum_two_phase();
    test_phase_clamp();
    test_backpressure();
    test_kill();
    test_reset_mid_op();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
